// File: rtl/ahb_master_arbiter_if.sv
// Downstream bus between the channel arbiter and the single-port AHB master.
// Signal names are as seen from the arbiter side.
interface ahb_master_arbiter_if #(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32
);
  logic                o_m_idle;
  logic                o_m_first_xfer;
  logic                o_m_wr;
  logic                o_m_rd;
  logic [DATA_WDT-1:0] o_m_wr_data;
  logic                o_m_wr_data_dav;
  logic [31:0]         o_m_addr;
  logic [2:0]          o_m_size;
  logic [BEAT_WDT-1:0] o_m_min_len;
  logic                i_m_stall;
  logic [DATA_WDT-1:0] i_m_data;
  logic [31:0]         i_m_addr;
  logic                i_m_dav;

  modport master (
    output o_m_idle, o_m_first_xfer, o_m_wr, o_m_rd, o_m_wr_data,
           o_m_wr_data_dav, o_m_addr, o_m_size, o_m_min_len,
    input  i_m_stall, i_m_data, i_m_addr, i_m_dav
  );

  modport slave (
    input  o_m_idle, o_m_first_xfer, o_m_wr, o_m_rd, o_m_wr_data,
           o_m_wr_data_dav, o_m_addr, o_m_size, o_m_min_len,
    output i_m_stall, i_m_data, i_m_addr, i_m_dav
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// N-channel burst-granular round-robin arbiter in front of the AHB master.
// Read responses come back in order; a tag FIFO remembers which channel
// issued each outstanding read beat so the response can be routed back.
module ahb_master_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_WDT  = 32,
  parameter int BEAT_WDT  = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         i_hclk,
  input  logic                         i_hreset,
  input  logic [NUM_CH-1:0]            i_s_valid,
  input  logic [NUM_CH-1:0]            i_s_first,
  input  logic [NUM_CH-1:0]            i_s_last,
  input  logic [NUM_CH-1:0]            i_s_wr,
  input  logic [NUM_CH-1:0]            i_s_rd,
  input  logic [NUM_CH*DATA_WDT-1:0]   i_s_wr_data,
  input  logic [NUM_CH-1:0]            i_s_wr_data_dav,
  input  logic [NUM_CH*32-1:0]         i_s_addr,
  input  logic [NUM_CH*3-1:0]          i_s_size,
  input  logic [NUM_CH*BEAT_WDT-1:0]   i_s_min_len,
  output logic [NUM_CH-1:0]            o_s_stall,
  output logic [NUM_CH-1:0]            o_rsp_dav,
  output logic [DATA_WDT-1:0]          o_rsp_data,
  output logic [31:0]                  o_rsp_addr,
  output logic [1:0]                   o_err,
  ahb_master_arbiter_if.master         m_bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(TAG_DEPTH);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_own, r_rr;
  logic                r_fb;
  logic [CW-1:0]       r_tag [TAG_DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [PW:0]         r_cnt;
  logic [NUM_CH-1:0]   r_rsp_dav;
  logic [DATA_WDT-1:0] r_rsp_data;
  logic [31:0]         r_rsp_addr;
  logic [1:0]          r_err;

  logic [NUM_CH-1:0]   w_req;
  logic                w_found;
  logic [CW-1:0]       w_win;
  logic                w_in_own, w_v, w_full, w_own_stall;
  logic                w_acc, w_cmp, w_eob, w_push, w_pop;

  assign w_req       = i_s_valid & i_s_first;
  assign w_in_own    = (r_state == S_OWN);
  assign w_v         = i_s_valid[r_own];
  // Full is judged on the pre-pop count, so a read stalls at full even in a pop cycle.
  assign w_full      = (r_cnt == CNT_FULL);
  assign w_own_stall = m_bus.i_m_stall | (i_s_rd[r_own] & w_full);
  assign w_acc       = w_in_own & w_v & ~w_own_stall;
  assign w_cmp       = w_acc & (i_s_rd[r_own] | (i_s_wr[r_own] & i_s_wr_data_dav[r_own]));
  assign w_eob       = w_cmp & i_s_last[r_own];
  assign w_push      = w_acc & i_s_rd[r_own];
  assign w_pop       = m_bus.i_m_dav & (r_cnt != '0);

  assign o_rsp_dav  = r_rsp_dav;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_addr = r_rsp_addr;
  assign o_err      = r_err;

  // Round-robin pick: first requester at or above rr, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && w_req[(int'(r_rr) + i) % NUM_CH]) begin
        w_found = 1'b1;
        w_win   = CW'((int'(r_rr) + i) % NUM_CH);
      end
    end
  end

  // Downstream mux from the owning channel; everyone else is held off.
  always_comb begin
    o_s_stall               = '1;
    m_bus.o_m_idle          = 1'b1;
    m_bus.o_m_first_xfer    = 1'b0;
    m_bus.o_m_wr            = 1'b0;
    m_bus.o_m_rd            = 1'b0;
    m_bus.o_m_wr_data       = '0;
    m_bus.o_m_wr_data_dav   = 1'b0;
    m_bus.o_m_addr          = '0;
    m_bus.o_m_size          = '0;
    m_bus.o_m_min_len       = '0;
    if (w_in_own) begin
      o_s_stall[r_own]      = w_own_stall;
      m_bus.o_m_idle        = ~w_v;
      m_bus.o_m_first_xfer  = w_v & r_fb;
      m_bus.o_m_wr          = i_s_wr[r_own];
      m_bus.o_m_rd          = i_s_rd[r_own];
      m_bus.o_m_wr_data     = i_s_wr_data[r_own*DATA_WDT +: DATA_WDT];
      m_bus.o_m_wr_data_dav = i_s_wr_data_dav[r_own];
      m_bus.o_m_addr        = i_s_addr[r_own*32 +: 32];
      m_bus.o_m_size        = i_s_size[r_own*3 +: 3];
      m_bus.o_m_min_len     = i_s_min_len[r_own*BEAT_WDT +: BEAT_WDT];
    end
  end

  // Ownership FSM: grant on a first-beat request, release on the last completing beat.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state <= S_IDLE;
      r_own   <= '0;
      r_rr    <= '0;
      r_fb    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_state <= S_OWN;
          r_own   <= w_win;
          r_fb    <= 1'b1;
        end
        S_OWN: begin
          if (w_acc) r_fb <= 1'b0;
          if (w_eob) begin
            r_state <= S_IDLE;
            r_rr    <= (int'(r_own) == NUM_CH-1) ? '0 : r_own + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag storage needs no reset; validity is carried by the count.
  always_ff @(posedge i_hclk) begin
    if (w_push) r_tag[r_wp] <= r_own;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response routing and sticky error flags.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_rsp_dav  <= '0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_err      <= '0;
    end else begin
      r_rsp_dav <= '0;
      if (w_pop) r_rsp_dav[r_tag[r_rp]] <= 1'b1;
      if (m_bus.i_m_dav) begin
        r_rsp_data <= m_bus.i_m_data;
        r_rsp_addr <= m_bus.i_m_addr;
      end
      if (m_bus.i_m_dav && r_cnt == '0) r_err[0] <= 1'b1;
      if (w_in_own && !r_fb && !w_v)    r_err[1] <= 1'b1;
    end
  end
endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

N-channel command arbiter that sits in front of `ahb_master_top` and multiplexes several independent user command ports onto its single user interface. Ownership is granted round-robin at burst granularity. Read responses return in order and are routed back to the issuing channel through a channel-tag FIFO. This makes the block the multi-client successor of the single-port AHB master front end.

## Interface

Parameters:

- NUM_CH, 4, number of user channels (2..16).
- DATA_WDT, 32, data width; matches the downstream master.
- BEAT_WDT, 32, width of min_len; matches the downstream master.
- TAG_DEPTH, 8, maximum outstanding read beats; power of two, ≥2.

Ports. Per-channel buses are flattened; channel c occupies slice c.

- i_hclk, in, 1, clock. One clock domain only; all logic rises on i_hclk.
- i_hreset, in, 1, reset. Synchronous and active-high.
- i_s_valid, in, NUM_CH, channel presents a beat.
- i_s_first, in, NUM_CH, beat is the first of a burst.
- i_s_last, in, NUM_CH, beat is the last of a burst.
- i_s_wr, in, NUM_CH, write burst.
- i_s_rd, in, NUM_CH, read beat.
- i_s_wr_data, in, NUM_CH*DATA_WDT, write data.
- i_s_wr_data_dav, in, NUM_CH, write data valid.
- i_s_addr, in, NUM_CH*32, burst base address.
- i_s_size, in, NUM_CH*3, hsize.
- i_s_min_len, in, NUM_CH*BEAT_WDT, minimum number of beats.
- o_s_stall, out, NUM_CH, per-channel stall.
- o_rsp_dav, out, NUM_CH, one-hot read response valid.
- o_rsp_data, out, DATA_WDT, read data; common to all channels.
- o_rsp_addr, out, 32, read address; common to all channels.
- o_m_idle, out, 1, to downstream i_idle.
- o_m_first_xfer, out, 1, to downstream i_first_xfer.
- o_m_wr, out, 1, to downstream i_wr.
- o_m_rd, out, 1, to downstream i_rd.
- o_m_wr_data, out, DATA_WDT, to downstream i_wr_data.
- o_m_wr_data_dav, out, 1, to downstream i_wr_data_dav.
- o_m_addr, out, 32, to downstream i_addr.
- o_m_size, out, 3, to downstream i_size.
- o_m_min_len, out, BEAT_WDT, to downstream i_min_len.
- i_m_stall, in, 1, from downstream o_stall.
- i_m_data, in, DATA_WDT, from downstream o_data.
- i_m_addr, in, 32, from downstream o_addr.
- i_m_dav, in, 1, from downstream o_dav.
- o_err, out, 2, sticky errors. Bit 0 is response with an empty tag FIFO; bit 1 is s_valid dropped mid-burst.

## Operation

The arbiter is a two-state FSM, IDLE and OWN. It keeps a registered owner index `own` and a round-robin pointer `rr`.

- **IDLE**
  - Downstream: o_m_idle=1; other o_m_* outputs are don't-care (zero).
  - o_s_stall = all ones.
  - A request is i_s_valid[c] & i_s_first[c].
  - If any request exists, the winner is the first requester at or after `rr`, searching upward modulo NUM_CH. Set `own` to the winner and go to OWN.
- **OWN**
  - All o_m_* outputs are muxed from channel `own`.
  - o_m_idle = ~i_s_valid[own].
  - o_m_first_xfer = i_s_valid[own] & `fb`, where `fb` is a flag set on entry to OWN and cleared on the first accepted beat.
  - o_s_stall[own] = i_m_stall | (i_s_rd[own] & tag_full). All other channels see stall=1.
- **Accepted beat**: i_s_valid[own] & ~o_s_stall[own].
- **Completing beat**: an accepted beat with (i_s_rd | (i_s_wr & i_s_wr_data_dav)).
- **End of burst**: a completing beat with i_s_last[own]=1 sends the FSM to IDLE and sets rr = (own+1) mod NUM_CH.
- **Protocol violation**: i_s_valid[own]=0 while in OWN after the first accepted beat sets o_err[1]. The value is still forwarded downstream.
- **Tag FIFO**: TAG_DEPTH entries, each $clog2(NUM_CH) bits wide.
  - Push `own` on every accepted beat with o_m_rd=1.
  - Pop on i_m_dav.
  - tag_full is count==TAG_DEPTH, evaluated before any same-cycle pop, so reads stall at full even when a pop occurs that cycle.
  - The count is $clog2(TAG_DEPTH)+1 bits wide; read and write pointers wrap modulo TAG_DEPTH.
- **Response**: registered one cycle after i_m_dav.
  - o_rsp_dav = one-hot of the popped tag.
  - o_rsp_data and o_rsp_addr are registered copies of i_m_data and i_m_addr.
- **Empty pop**: i_m_dav with the FIFO empty sets o_err[0]; o_rsp_dav stays 0 and the count stays 0.

## Timing

- **Reset** (synchronous, i_hreset=1 at the clock edge):
  - FSM = IDLE, rr=0, own=0, fb=0.
  - FIFO empty, o_rsp_dav=0, o_rsp_data=0, o_rsp_addr=0, o_err=0.
  - Consequently o_m_idle=1 and o_s_stall all ones.
  - Reset during OWN abandons the burst and discards outstanding tags; no response is routed after reset.
- **Grant latency**: a request seen in cycle T becomes owner in T+1. The first beat can be accepted in T+1 if i_m_stall=0.
- **Gap between bursts**: exactly one IDLE cycle between the last beat of one burst and the first beat of the next, including same-channel back-to-back bursts.
- **Response latency**: i_m_dav in cycle T produces o_rsp_dav in T+1. Full throughput is one response per cycle.
- **Simultaneous push and pop**: below full, the count is unchanged.
- **Write paths**: the write data path is combinational; the arbiter adds no cycle to write beats.

## Test plan

- **Single read burst**: ch2 issues a 4-beat read at 0x1000 with the downstream never stalling. Expect grant one cycle after request, o_m_first_xfer=1 on beat 0 only, four o_rsp_dav=4'b0100 pulses each one cycle after i_m_dav, then return to IDLE.
- **Round-robin fairness**: all 4 channels request continuously with 1-beat bursts and rr=0. Expect grant order 0,1,2,3,0, with one IDLE cycle between bursts.
- **Tag full**: TAG_DEPTH=8, ch1 issues a 12-beat read and the response path is held off. Expect o_s_stall[1]=1 after 8 accepted beats. Then 1 response releases exactly 1 further beat, and all 12 responses are routed to ch1 in order.
- **Interleaved routing**: a ch0 3-beat read is followed by a ch3 2-beat read, with responses delayed. Expect o_rsp_dav sequence 0001,0001,0001,1000,1000.
- **Write with gapping**: ch1 issues a 4-beat write with i_s_wr_data_dav toggling 1,0,1,1,0,1. Expect FSM exit only after the 4th dav beat carrying last, with no tag pushes.
- **Errors and reset**: i_m_dav with the FIFO empty gives o_err=2'b01. A valid drop mid-burst sets bit 1. i_hreset=1 for one cycle mid-burst clears o_err and returns o_m_idle=1 on the next cycle.
